// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - shared types and defaults for the PLL lock supervisor
// Purpose: supervisor state enum, default parameter values and a constant helper
//          used to size the shared state timer.
// Ports:   none (package).
package pll_sup_pkg;

  localparam int unsigned DEF_RST_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 65536;
  localparam int unsigned DEF_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_CNT_W         = 8;
  localparam int unsigned DEF_MAX_RETRIES   = 4;

  // S_FAIL is only reachable when the retry limit is compiled in.
  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } pll_sup_state_t;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// rtl/pll_lock_supervisor_if.sv - PLL control/status bundle between board side and supervisor
// Purpose: groups the PLL lock input, status clear and all supervisor outputs.
// Signals: locked, clear_status      (board/PLL side -> supervisor)
//          pll_rst, sys_rst, clk_ok, lock_lost, relock_cnt[CNT_W], fail
//                                      (supervisor -> PLL / reset tree / status)
// Modports: master = board/PLL side, slave = supervisor.
interface pll_lock_supervisor_if
  import pll_sup_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) ();

  logic             locked;
  logic             clear_status;
  logic             pll_rst;
  logic             sys_rst;
  logic             clk_ok;
  logic             lock_lost;
  logic [CNT_W-1:0] relock_cnt;
  logic             fail;

  modport master (
    output locked, clear_status,
    input  pll_rst, sys_rst, clk_ok, lock_lost, relock_cnt, fail
  );

  modport slave (
    input  locked, clear_status,
    output pll_rst, sys_rst, clk_ok, lock_lost, relock_cnt, fail
  );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic 1-bit double-flop synchronizer
// Purpose: brings an asynchronous level into the i_clk domain.
// Ports:   i_clk  - destination clock
//          i_rst  - asynchronous active-high reset, clears both flops to 0
//          i_d    - asynchronous input level
//          o_q    - synchronized level, 2-3 cycles behind i_d
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset/lock sequencer feeding the output-domain reset tree
// Purpose: holds the PLL in reset, waits for lock, requires lock to stay stable
//          before releasing sys_rst, and restarts on lock loss or lock timeout.
// Ports:   refclk - 50 MHz reference clock, the only clock
//          rst    - asynchronous active-high reset
//          bus    - pll_lock_supervisor_if.slave (locked, clear_status in;
//                   pll_rst, sys_rst, clk_ok, lock_lost, relock_cnt, fail out)
// Build option: PLL_SUP_RETRY_LIMIT_EN enables the retry limit and FAIL state;
//               without it retries never stop and fail is tied 0.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic                   refclk,
  input  logic                   rst,
  pll_lock_supervisor_if.slave   bus
);

  localparam int unsigned TMR_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  pll_sup_state_t   r_state;
  pll_sup_state_t   w_next;
  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] w_tmr_load;
  logic             w_locked_s;
  logic             w_tmr_zero;
  logic             w_timeout;
  logic             w_loss;
  logic             w_retry_last;

  logic             w_pll_rst, w_sys_rst, w_clk_ok, w_fail;
  logic             r_pll_rst, r_sys_rst, r_clk_ok, r_fail;
  logic             r_lock_lost;
  logic [CNT_W-1:0] r_relock_cnt;

  sync_2ff u_locked_sync (
    .i_clk (refclk),
    .i_rst (rst),
    .i_d   (bus.locked),
    .o_q   (w_locked_s)
  );

  assign w_tmr_zero = (r_tmr == '0);
  assign w_timeout  = (r_state == S_WAIT_LOCK) && !w_locked_s && w_tmr_zero;
  assign w_loss     = (r_state == S_RUN) && !w_locked_s;

`ifdef PLL_SUP_RETRY_LIMIT_EN
  localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);
  logic [RETRY_W-1:0] r_retry;

  // The timeout that brings the consecutive count up to MAX_RETRIES is the one that fails.
  assign w_retry_last = (r_retry == RETRY_W'(MAX_RETRIES - 1));

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_retry <= '0;
    end else if (r_state == S_STABLE && w_next == S_RUN) begin
      r_retry <= '0;
    end else if (w_timeout) begin
      r_retry <= r_retry + 1'b1;
    end
  end
`else
  assign w_retry_last = 1'b0;
`endif

  // State register plus the shared down-counter, reloaded on every state entry.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state <= S_RESET_PLL;
      r_tmr   <= TMR_W'(RST_CYCLES - 1);
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_tmr <= w_tmr_load;
      end else if (!w_tmr_zero) begin
        r_tmr <= r_tmr - 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET_PLL: if (w_tmr_zero) w_next = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (w_locked_s) begin
          w_next = S_STABLE;
        end else if (w_tmr_zero) begin
          w_next = w_retry_last ? S_FAIL : S_RESET_PLL;
        end
      end
      S_STABLE: begin
        if (!w_locked_s) begin
          w_next = S_WAIT_LOCK;
        end else if (w_tmr_zero) begin
          w_next = S_RUN;
        end
      end
      S_RUN: if (!w_locked_s) w_next = S_RESET_PLL;
`ifdef PLL_SUP_RETRY_LIMIT_EN
      S_FAIL: w_next = S_FAIL;
`endif
      default: w_next = S_RESET_PLL;
    endcase
  end

  always_comb begin
    w_tmr_load = '0;
    case (w_next)
      S_RESET_PLL: w_tmr_load = TMR_W'(RST_CYCLES - 1);
      S_WAIT_LOCK: w_tmr_load = TMR_W'(LOCK_TIMEOUT - 1);
      S_STABLE:    w_tmr_load = TMR_W'(STABLE_CYCLES - 1);
      default:     w_tmr_load = '0;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they switch
  // on the same edge as the state and never glitch.
  always_comb begin
    w_pll_rst = 1'b1;
    w_sys_rst = 1'b1;
    w_clk_ok  = 1'b0;
    w_fail    = 1'b0;
    case (w_next)
      S_WAIT_LOCK, S_STABLE: w_pll_rst = 1'b0;
      S_RUN: begin
        w_pll_rst = 1'b0;
        w_sys_rst = 1'b0;
        w_clk_ok  = 1'b1;
      end
`ifdef PLL_SUP_RETRY_LIMIT_EN
      S_FAIL: w_fail = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_pll_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_clk_ok  <= 1'b0;
      r_fail    <= 1'b0;
    end else begin
      r_pll_rst <= w_pll_rst;
      r_sys_rst <= w_sys_rst;
      r_clk_ok  <= w_clk_ok;
      r_fail    <= w_fail;
    end
  end

  // A clear in the same cycle as a loss/timeout wins; that event is dropped.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_relock_cnt <= '0;
      r_lock_lost  <= 1'b0;
    end else if (bus.clear_status) begin
      r_relock_cnt <= '0;
      r_lock_lost  <= 1'b0;
    end else begin
      if ((w_timeout || w_loss) && r_relock_cnt != CNT_SAT) begin
        r_relock_cnt <= r_relock_cnt + 1'b1;
      end
      if (w_loss) begin
        r_lock_lost <= 1'b1;
      end
    end
  end

  assign bus.pll_rst    = r_pll_rst;
  assign bus.sys_rst    = r_sys_rst;
  assign bus.clk_ok     = r_clk_ok;
  assign bus.fail       = r_fail;
  assign bus.lock_lost  = r_lock_lost;
  assign bus.relock_cnt = r_relock_cnt;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - self-checking bench for pll_lock_supervisor
// Purpose: directed scenarios plus randomized lock waveforms checked every cycle
//          against a behavioural phase/age model. Honours PLL_SUP_RETRY_LIMIT_EN.
module tb_pll_lock_supervisor;

  localparam int RST_C = 4;
  localparam int TO_C  = 20;
  localparam int ST_C  = 8;
  localparam int CW    = 2;
  localparam int MR    = 2;
  localparam int CMAX  = (1 << CW) - 1;

  localparam int P_RST  = 0;
  localparam int P_WAIT = 1;
  localparam int P_STAB = 2;
  localparam int P_RUN  = 3;
  localparam int P_FAIL = 4;

  logic refclk = 1'b0;
  logic rst    = 1'b1;

  pll_lock_supervisor_if #(.CNT_W(CW)) bus ();

  pll_lock_supervisor #(
    .RST_CYCLES    (RST_C),
    .LOCK_TIMEOUT  (TO_C),
    .STABLE_CYCLES (ST_C),
    .CNT_W         (CW),
    .MAX_RETRIES   (MR)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 refclk = ~refclk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase, cycles spent in the phase, and the two most recent
  // locked samples (the FSM acts on the older one).
  int m_phase, m_age, m_cnt, m_retry;
  bit m_lost, m_h1, m_h2;

  always @(posedge refclk or posedge rst) begin
    if (rst) begin
      m_phase = P_RST; m_age = 0; m_cnt = 0; m_retry = 0;
      m_lost = 0; m_h1 = 0; m_h2 = 0;
    end else begin
      bit ls, inc, loss;
      int nxt;
      ls = m_h2; m_h2 = m_h1; m_h1 = bus.locked;
      inc = 0; loss = 0; nxt = m_phase;
      case (m_phase)
        P_RST:  if (m_age + 1 >= RST_C) nxt = P_WAIT;
        P_WAIT: begin
          if (ls) nxt = P_STAB;
          else if (m_age + 1 >= TO_C) begin
            inc = 1; m_retry++;
`ifdef PLL_SUP_RETRY_LIMIT_EN
            nxt = (m_retry >= MR) ? P_FAIL : P_RST;
`else
            nxt = P_RST;
`endif
          end
        end
        P_STAB: begin
          if (!ls) nxt = P_WAIT;
          else if (m_age + 1 >= ST_C) begin nxt = P_RUN; m_retry = 0; end
        end
        P_RUN:  if (!ls) begin nxt = P_RST; inc = 1; loss = 1; end
        default: nxt = m_phase;
      endcase
      if (bus.clear_status) begin
        m_cnt = 0; m_lost = 0;
      end else begin
        if (inc && m_cnt < CMAX) m_cnt++;
        if (loss) m_lost = 1;
      end
      m_age = (nxt == m_phase) ? m_age + 1 : 0;
      m_phase = nxt;
    end
  end

  function automatic logic [6:0] dut_vec();
    return {bus.pll_rst, bus.sys_rst, bus.clk_ok, bus.lock_lost, bus.relock_cnt, bus.fail};
  endfunction

  function automatic logic [6:0] model_vec();
    logic [1:0] c;
    c = m_cnt[1:0];
    return {(m_phase == P_RST) || (m_phase == P_FAIL), m_phase != P_RUN, m_phase == P_RUN,
            m_lost, c, m_phase == P_FAIL};
  endfunction

  task automatic step();
    @(posedge refclk);
    @(negedge refclk);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.locked = 0; bus.clear_status = 0; rst = 1'b1;
    repeat (3) step();
    checks++;
    if (dut_vec() !== 7'b1100000) begin
      errors++; $display("FAIL reset_values: got=%b want=%b", dut_vec(), 7'b1100000);
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL reset_model: dut=%b model=%b", dut_vec(), model_vec());
    end
  endtask

  task automatic test_lock_seq();
    int pr_cnt, rise_at, fall_at;
    bit pr_done;
    rst = 1'b0; bus.locked = 0;
    pr_cnt = 0; pr_done = 0; rise_at = 10; fall_at = -1;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) step();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL lock_seq_model cyc=%0d dut=%b model=%b", i, dut_vec(), model_vec());
      end
      if (!pr_done) begin
        if (bus.pll_rst) pr_cnt++; else pr_done = 1;
      end
      if (i > rise_at && fall_at < 0 && bus.sys_rst === 1'b0) fall_at = i;
      if (i == rise_at) bus.locked = 1;
      if (fall_at >= 0 && i > fall_at + 2) break;
    end
    checks++;
    if (pr_cnt !== RST_C) begin
      errors++; $display("FAIL pll_rst_width: got=%0d want=%0d", pr_cnt, RST_C);
    end
    checks++;
    if (fall_at < 0 || fall_at - rise_at < 3 + ST_C - 1 || fall_at - rise_at > 3 + ST_C + 1) begin
      errors++; $display("FAIL lock_to_sys_rst: got=%0d want=%0d+-1", fall_at - rise_at, 3 + ST_C);
    end
    checks++;
    if (bus.clk_ok !== 1'b1) begin
      errors++; $display("FAIL clk_ok_run: got=%b want=1", bus.clk_ok);
    end
  endtask

  task automatic test_lock_loss();
    int rise_i, prc;
    rise_i = -1; prc = 0;
    bus.locked = 0;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) step();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL loss_model cyc=%0d dut=%b model=%b", i, dut_vec(), model_vec());
      end
      if (i == 5) bus.locked = 1;
      if (rise_i < 0 && bus.sys_rst === 1'b1) begin
        rise_i = i;
        checks++;
        if (bus.lock_lost !== 1'b1 || bus.relock_cnt !== 2'd1) begin
          errors++; $display("FAIL loss_status: got lost=%b cnt=%0d want lost=1 cnt=1",
                             bus.lock_lost, bus.relock_cnt);
        end
      end
      if (bus.pll_rst) prc++;
      if (i > 20 && bus.clk_ok) break;
    end
    checks++;
    if (rise_i < 1 || rise_i > 4) begin
      errors++; $display("FAIL loss_latency: got=%0d want=1..4", rise_i);
    end
    checks++;
    if (prc !== RST_C) begin
      errors++; $display("FAIL relock_pll_rst_width: got=%0d want=%0d", prc, RST_C);
    end
    checks++;
    if (bus.clk_ok !== 1'b1) begin
      errors++; $display("FAIL relock_run: got clk_ok=%b want=1", bus.clk_ok);
    end
  endtask

  task automatic test_stable_glitch();
    int glitch_at, up_at, fall_at;
    glitch_at = -1; up_at = -1; fall_at = -1;
    bus.locked = 1;
    pulse_rst();
    for (int i = 0; i < 120; i++) begin
      if (i > 0) step();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL glitch_model cyc=%0d dut=%b model=%b", i, dut_vec(), model_vec());
      end
      if (up_at >= 0 && fall_at < 0 && bus.sys_rst === 1'b0) fall_at = i;
      if (glitch_at < 0 && m_phase == P_STAB && m_age == 4) begin
        glitch_at = i; bus.locked = 0;
      end else if (glitch_at >= 0 && up_at < 0 && i == glitch_at + 2) begin
        bus.locked = 1; up_at = i;
      end
      if (fall_at >= 0) break;
    end
    checks++;
    if (fall_at < 0 || fall_at - up_at < 3 + ST_C - 1 || fall_at - up_at > 3 + ST_C + 1) begin
      errors++; $display("FAIL stable_restart: got=%0d want=%0d+-1", fall_at - up_at, 3 + ST_C);
    end
    checks++;
    if (bus.relock_cnt !== 2'd0 || bus.lock_lost !== 1'b0) begin
      errors++; $display("FAIL glitch_status: got cnt=%0d lost=%b want cnt=0 lost=0",
                         bus.relock_cnt, bus.lock_lost);
    end
  endtask

  task automatic test_timeout();
    int last_rise, n_rise, fail_at;
    bit prev_pr;
    bus.locked = 0;
    pulse_rst();
    last_rise = 0; n_rise = 0; fail_at = -1; prev_pr = 1;
    for (int i = 0; i < 200; i++) begin
      if (i > 0) step();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL timeout_model cyc=%0d dut=%b model=%b", i, dut_vec(), model_vec());
      end
      if (bus.pll_rst && !prev_pr) begin
        n_rise++;
        checks++;
        if (i - last_rise !== RST_C + TO_C) begin
          errors++; $display("FAIL retry_period: got=%0d want=%0d", i - last_rise, RST_C + TO_C);
        end
        last_rise = i;
      end
      prev_pr = bus.pll_rst;
      if (fail_at < 0 && bus.fail === 1'b1) fail_at = i;
    end
`ifdef PLL_SUP_RETRY_LIMIT_EN
    checks++;
    if (fail_at !== MR * (RST_C + TO_C)) begin
      errors++; $display("FAIL fail_time: got=%0d want=%0d", fail_at, MR * (RST_C + TO_C));
    end
    checks++;
    if (bus.fail !== 1'b1 || bus.pll_rst !== 1'b1 || bus.relock_cnt !== 2'(MR)) begin
      errors++; $display("FAIL fail_hold: got fail=%b pll_rst=%b cnt=%0d want 1 1 %0d",
                         bus.fail, bus.pll_rst, bus.relock_cnt, MR);
    end
    rst = 1'b1; #1;
    checks++;
    if (dut_vec() !== 7'b1100000) begin
      errors++; $display("FAIL fail_exit_rst: got=%b want=%b", dut_vec(), 7'b1100000);
    end
    @(negedge refclk); rst = 1'b0; step();
    checks++;
    if (bus.fail !== 1'b0 || bus.pll_rst !== 1'b1) begin
      errors++; $display("FAIL after_fail_rst: got fail=%b pll_rst=%b want 0 1", bus.fail, bus.pll_rst);
    end
`else
    checks++;
    if (n_rise !== 200 / (RST_C + TO_C)) begin
      errors++; $display("FAIL retry_count: got=%0d want=%0d", n_rise, 200 / (RST_C + TO_C));
    end
    checks++;
    if (bus.relock_cnt !== 2'(CMAX) || bus.fail !== 1'b0 || fail_at !== -1) begin
      errors++; $display("FAIL saturate: got cnt=%0d fail=%b want cnt=%0d fail=0",
                         bus.relock_cnt, bus.fail, CMAX);
    end
`endif
  endtask

  task automatic test_clear_collision();
    int st, t0;
    st = 0; t0 = 0;
    bus.locked = 1;
    pulse_rst();
    for (int i = 0; i < 300; i++) begin
      if (i > 0) step();
      bus.clear_status = 0;
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL clear_model cyc=%0d dut=%b model=%b", i, dut_vec(), model_vec());
      end
      case (st)
        0: if (bus.clk_ok) begin bus.locked = 0; t0 = i; st = 1; end
        1: if (i == t0 + 3) begin bus.locked = 1; st = 2; end
        2: if (bus.clk_ok) begin
             checks++;
             if (bus.relock_cnt !== 2'd1 || bus.lock_lost !== 1'b1) begin
               errors++; $display("FAIL pre_clear: got cnt=%0d lost=%b want 1 1",
                                  bus.relock_cnt, bus.lock_lost);
             end
             bus.locked = 0; st = 3;
           end
        3: if (m_phase == P_RUN && !m_h2) begin bus.clear_status = 1; t0 = i; st = 4; end
        4: if (i == t0 + 1) begin
             checks++;
             if (bus.sys_rst !== 1'b1 || bus.relock_cnt !== 2'd0 || bus.lock_lost !== 1'b0) begin
               errors++; $display("FAIL clear_priority: got sys_rst=%b cnt=%0d lost=%b want 1 0 0",
                                  bus.sys_rst, bus.relock_cnt, bus.lock_lost);
             end
             st = 5;
           end
        default: ;
      endcase
      if (st == 5) break;
    end
    checks++;
    if (st !== 5) begin
      errors++; $display("FAIL clear_timeout: got stage=%0d want=5", st);
    end
  endtask

  task automatic test_rst_midwait();
    bit found;
    found = 0;
    bus.locked = 0;
    pulse_rst();
    for (int i = 0; i < 100; i++) begin
      if (i > 0) step();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL midwait_model cyc=%0d dut=%b model=%b", i, dut_vec(), model_vec());
      end
      if (m_phase == P_WAIT && m_age == 5 && m_cnt > 0) begin found = 1; break; end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL midwait_reach: got=0 want=1");
    end
    @(posedge refclk); #2; rst = 1'b1; #1;
    checks++;
    if (dut_vec() !== 7'b1100000) begin
      errors++; $display("FAIL async_rst: got=%b want=%b", dut_vec(), 7'b1100000);
    end
    @(negedge refclk); rst = 1'b0;
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    bus.locked = 0;
    pulse_rst();
    for (int i = 0; i < 3000; i++) begin
      if (i > 0) step();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL random_model cyc=%0d dut=%b model=%b", i, dut_vec(), model_vec());
      end
      bus.clear_status = ($urandom_range(0, 39) == 0);
      if (hold == 0) begin
        bus.locked = ~bus.locked;
        hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 40));
      end
      hold--;
    end
    bus.clear_status = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.locked = 0;
    bus.clear_status = 0;
    test_reset();
    test_lock_seq();
    test_lock_loss();
    test_stable_glitch();
    test_timeout();
    test_clear_collision();
    test_rst_midwait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
